// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - E-stage hazard/sequencing bus between pipeline and hazard_sequencer
interface hazard_sequencer_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] Rs1D_i;
    logic [REG_AW-1:0] Rs2D_i;
    logic [REG_AW-1:0] Rs1E_i;
    logic [REG_AW-1:0] Rs2E_i;
    logic [REG_AW-1:0] RdE_i;
    logic [REG_AW-1:0] RdM_i;
    logic [REG_AW-1:0] RdW_i;
    logic              RegWriteM_i;
    logic              RegWriteW_i;
    logic              LoadE_i;
    logic [1:0]        PCSrcE_i;
    logic              MulDivE_i;
    logic              MdDone_i;
    logic [1:0]        ForwardAE_o;
    logic [1:0]        ForwardBE_o;
    logic              StallF_o;
    logic              StallD_o;
    logic              StallE_o;
    logic              FlushD_o;
    logic              FlushE_o;
    logic              BubbleM_o;
    logic              MdStart_o;
    logic              MdSel_o;
    logic              MdTimeout_o;

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
        output RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i, MulDivE_i, MdDone_i,
        input  ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o,
        input  FlushD_o, FlushE_o, BubbleM_o, MdStart_o, MdSel_o, MdTimeout_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
        input  RegWriteM_i, RegWriteW_i, LoadE_i, PCSrcE_i, MulDivE_i, MdDone_i,
        output ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o,
        output FlushD_o, FlushE_o, BubbleM_o, MdStart_o, MdSel_o, MdTimeout_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - E-stage forwarding, load-use/branch hazards and iterative mul/div sequencing
module hazard_sequencer #(
    parameter int REG_AW        = 5,
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic              clk,
    input  logic              rst,
    hazard_sequencer_if.slave bus
);
    localparam int CW = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_md_timeout;
    logic            w_timeout_set;
    logic            w_md_start;
    logic            w_md_sel;
    logic            w_md;
    logic            w_lw;
    logic            w_br;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_md_timeout <= r_md_timeout | w_timeout_set;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_timeout_set = 1'b0;
        w_md_start    = 1'b0;
        w_md_sel      = 1'b0;
        w_md          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.MulDivE_i) begin
                    w_md_start   = 1'b1;
                    w_md         = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_md = 1'b1;
                // Saturating so a long-stuck unit can never wrap past the watchdog compare
                if (r_cnt != {CW{1'b1}}) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (bus.MdDone_i) begin
                    w_state_next = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_set = 1'b1;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_md_sel     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (bus.RegWriteM_i && (bus.RdM_i != '0) && (bus.RdM_i == bus.Rs1E_i)) begin
            w_fwd_a = 2'b10;
        end else if (bus.RegWriteW_i && (bus.RdW_i != '0) && (bus.RdW_i == bus.Rs1E_i)) begin
            w_fwd_a = 2'b01;
        end
        if (bus.RegWriteM_i && (bus.RdM_i != '0) && (bus.RdM_i == bus.Rs2E_i)) begin
            w_fwd_b = 2'b10;
        end else if (bus.RegWriteW_i && (bus.RdW_i != '0) && (bus.RdW_i == bus.Rs2E_i)) begin
            w_fwd_b = 2'b01;
        end
    end

    assign w_lw = bus.LoadE_i && (bus.RdE_i != '0) &&
                  ((bus.RdE_i == bus.Rs1D_i) || (bus.RdE_i == bus.Rs2D_i));
    assign w_br = (bus.PCSrcE_i != 2'b00);

    // A frozen mul/div in E must not be flushed, so md masks every flush
    assign bus.ForwardAE_o = w_fwd_a;
    assign bus.ForwardBE_o = w_fwd_b;
    assign bus.StallF_o    = w_lw | w_md;
    assign bus.StallD_o    = w_lw | w_md;
    assign bus.StallE_o    = w_md;
    assign bus.BubbleM_o   = w_md;
    assign bus.FlushD_o    = w_br & ~w_md;
    assign bus.FlushE_o    = (w_lw | w_br) & ~w_md;
    assign bus.MdStart_o   = w_md_start;
    assign bus.MdSel_o     = w_md_sel;
    assign bus.MdTimeout_o = r_md_timeout;
endmodule
